// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRA shifter: one power-of-two stage per cycle, MSB stage first.
// Start/ready handshake in; one-cycle result_valid pulse out, result held until the next completion.
module seq_shift_unit #(
    parameter int DATA_W = 32,
    parameter int SH_W   = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SH_W-1:0]   shamt,
    output logic              ready,
    output logic              busy,
    output logic              result_valid,
    output logic [DATA_W-1:0] result
);

    localparam int STEP_W = (SH_W > 1) ? $clog2(SH_W) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SH_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_work;
    logic [DATA_W-1:0]   r_result;
    logic                r_op;
    logic [SH_W-1:0]     r_sh;
    logic [STEP_W-1:0]   r_step;
    logic                r_ready;
    logic                r_busy;
    logic                r_valid;

    logic [STEP_W-1:0]   w_k;
    logic [SH_W-1:0]     w_amt;
    logic [DATA_W-1:0]   w_shifted;
    logic                w_accept;

    // Stage index counts down from SH_W-1 to 0 as step counts up.
    assign w_k   = LAST_STEP - r_step;
    assign w_amt = SH_W'(1) << w_k;

    always_comb begin
        w_shifted = r_work;
        if (r_sh[w_k]) begin
            if (r_op) begin
                w_shifted = DATA_W'($signed(r_work) >>> w_amt);
            end else begin
                w_shifted = r_work << w_amt;
            end
        end
    end

    assign w_accept = start && (r_state != S_RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_result <= '0;
            r_op     <= 1'b0;
            r_sh     <= '0;
            r_step   <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_valid <= 1'b0;
                    if (w_accept) begin
                        r_work  <= data_in;
                        r_op    <= op;
                        r_sh    <= shamt;
                        r_step  <= '0;
                        r_state <= S_RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_work <= w_shifted;
                    r_step <= r_step + STEP_W'(1);
                    if (r_step == LAST_STEP) begin
                        r_result <= w_shifted;
                        r_state  <= S_DONE;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_valid  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ready        = r_ready;
    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign result       = r_result;

endmodule
